vram_arbiter: RTL and testbench

//  Single owner of the PPU VRAM port and the palette_mem write port. Shares them between the
//  ppu_render fetch path (strict priority, never stalled) and the CPU $2006/$2007 path.
//  CPU accesses are held in a one-entry slot and issued only in idle port cycles.

---
 rtl/vram_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: single owner of the PPU VRAM port and the palette write port.
// The renderer fetch path has strict priority and is never stalled. CPU $2007
// accesses wait in a one-entry slot and issue only in cycles the renderer
// leaves idle. Also holds the $2006 address latch (v/w), the $2007 read buffer
// and the +1/+32 address auto-increment.
// Optional build macro: ARB_VBLANK_ONLY_EN restricts CPU issue to vblank=1.
module vram_arbiter #(
  parameter int RD_LATENCY = 1,   // VRAM read latency in cycles, 1..4
  parameter int ADDR_W     = 14   // PPU address width, 9..16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rnd_req,
  input  logic [15:0] rnd_addr,
  output logic        rnd_valid,
  output logic [7:0]  rnd_data,
  input  logic        cpu_addr_wr,
  input  logic        cpu_data_wr,
  input  logic        cpu_data_rd,
  input  logic [7:0]  cpu_wdata,
  input  logic        inc32,
  input  logic        vblank,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_busy,
  output logic [15:0] VRAM_addr,
  output logic        VRAM_WE,
  output logic [7:0]  VRAM_data_in,
  input  logic [7:0]  VRAM_data_out,
  output logic        palette_WE,
  output logic [4:0]  pal_addr,
  output logic [7:0]  palette_data_in
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_RND  = 2'd1,
    TAG_CPU  = 2'd2
  } tag_e;

  // IDLE: slot empty. ISSUE: slot holds a CPU op waiting for a free port cycle.
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] PAL_BASE      = ADDR_W'(16'h3F00);
  localparam logic [ADDR_W-1:0] PAL_READ_MASK = ADDR_W'(16'h2FFF);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] v_q, v_d;
  logic              w_q, w_d;
  logic              slotWrite_q;
  logic [ADDR_W-1:0] slotAddr_q;
  logic [7:0]        slotData_q;
  tag_e              tagPipe_q [RD_LATENCY];
  tag_e              tagIn;
  tag_e              tagOut;
  logic [7:0]        cpuRdata_q;

  logic              capture;
  logic              cpuAllowed;
  logic              grantRnd;
  logic              issueCpu;
  logic              slotIsPal;
  logic [4:0]        palAddrMirrored;
  logic [ADDR_W-1:0] incStep;
  logic              unusedBits;

`ifdef ARB_VBLANK_ONLY_EN
  assign cpuAllowed = vblank;
  assign unusedBits = ^{1'b0, rnd_addr};
`else
  assign cpuAllowed = 1'b1;
  assign unusedBits = ^{vblank, rnd_addr};
`endif

  // Renderer wins the port whenever it asks; gated by reset so every output is 0 in reset.
  assign grantRnd  = reset & rnd_req;
  assign capture   = (state_q == IDLE) & (cpu_data_wr | cpu_data_rd);
  assign issueCpu  = (state_q == ISSUE) & ~rnd_req & cpuAllowed;
  assign slotIsPal = (slotAddr_q >= PAL_BASE);
  assign incStep   = inc32 ? ADDR_W'(32) : ADDR_W'(1);

  // Palette entries 10/14/18/1C alias the backdrop entries 00/04/08/0C.
  assign palAddrMirrored = {slotAddr_q[4] & (slotAddr_q[1:0] != 2'b00), slotAddr_q[3:0]};

  // Address latch and auto-increment; a data strobe uses v before any same-cycle $2006 update.
  always_comb begin
    v_d = v_q;
    w_d = w_q;
    if (capture) begin
      v_d = v_q + incStep;
    end
    if (cpu_addr_wr) begin
      if (!w_q) begin
        v_d[ADDR_W-1:8] = cpu_wdata[ADDR_W-9:0];
      end else begin
        v_d[7:0] = cpu_wdata;
      end
      w_d = ~w_q;
    end
  end

  // Latch state and the one-entry CPU slot; write wins over a simultaneous read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q         <= '0;
      w_q         <= 1'b0;
      slotWrite_q <= 1'b0;
      slotAddr_q  <= '0;
      slotData_q  <= '0;
    end else begin
      v_q <= v_d;
      w_q <= w_d;
      if (capture) begin
        slotWrite_q <= cpu_data_wr;
        slotAddr_q  <= v_q;
        slotData_q  <= cpu_wdata;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: fill on a captured strobe, empty in the cycle the op issues.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture)  state_d = ISSUE;
      ISSUE:   if (issueCpu) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: per-cycle port ownership and the tag entering the read pipe.
  always_comb begin
    VRAM_addr       = '0;
    VRAM_WE         = 1'b0;
    VRAM_data_in    = '0;
    palette_WE      = 1'b0;
    pal_addr        = '0;
    palette_data_in = '0;
    tagIn           = TAG_NONE;
    if (grantRnd) begin
      VRAM_addr = 16'(rnd_addr[ADDR_W-1:0]);
      tagIn     = TAG_RND;
    end else if (issueCpu) begin
      if (slotWrite_q) begin
        if (slotIsPal) begin
          palette_WE      = 1'b1;
          pal_addr        = palAddrMirrored;
          palette_data_in = slotData_q;
        end else begin
          VRAM_addr    = 16'(slotAddr_q);
          VRAM_WE      = 1'b1;
          VRAM_data_in = slotData_q;
        end
      end else begin
        VRAM_addr = 16'(slotIsPal ? (slotAddr_q & PAL_READ_MASK) : slotAddr_q);
        tagIn     = TAG_CPU;
      end
    end
  end

  // Owner-tag pipe, one stage per cycle of VRAM read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tagPipe_q[i] <= TAG_NONE;
      end
    end else begin
      tagPipe_q[0] <= tagIn;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tagPipe_q[i] <= tagPipe_q[i-1];
      end
    end
  end

  assign tagOut = tagPipe_q[RD_LATENCY-1];

  // $2007 read buffer, refilled when a CPU-tagged read returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpuRdata_q <= '0;
    end else if (tagOut == TAG_CPU) begin
      cpuRdata_q <= VRAM_data_out;
    end
  end

  assign rnd_valid = (tagOut == TAG_RND);
  assign rnd_data  = rnd_valid ? VRAM_data_out : 8'h00;
  assign cpu_rdata = cpuRdata_q;
  assign cpu_busy  = (state_q == ISSUE);

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed, table-driven bench for vram_arbiter with a
// one-cycle-latency VRAM model. One vector is one clock cycle: inputs are
// driven at the falling edge and outputs compared 2 time units later.
module tb_vram_arbiter;

  typedef struct packed {
    logic        rndValid;
    logic [7:0]  rndData;
    logic [15:0] vramAddr;
    logic        vramWe;
    logic [7:0]  vramDin;
    logic        palWe;
    logic [4:0]  palAddr;
    logic [7:0]  palDin;
    logic        cpuBusy;
    logic [7:0]  cpuRdata;
  } outs_t;

  typedef struct packed {
    logic        rndReq;
    logic [15:0] rndAddr;
    logic        addrWr;
    logic        dataWr;
    logic        dataRd;
    logic [7:0]  wdata;
    logic        inc32;
    logic        vblank;
  } ins_t;

  typedef struct {
    ins_t  stim;
    outs_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rnd_req = 1'b0;
  logic [15:0] rnd_addr = '0;
  logic        rnd_valid;
  logic [7:0]  rnd_data;
  logic        cpu_addr_wr = 1'b0;
  logic        cpu_data_wr = 1'b0;
  logic        cpu_data_rd = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic        inc32 = 1'b0;
  logic        vblank = 1'b1;
  logic [7:0]  cpu_rdata;
  logic        cpu_busy;
  logic [15:0] VRAM_addr;
  logic        VRAM_WE;
  logic [7:0]  VRAM_data_in;
  logic [7:0]  VRAM_data_out = '0;
  logic        palette_WE;
  logic [4:0]  pal_addr;
  logic [7:0]  palette_data_in;

  logic [7:0]  mem [16384];
  int          vectors = 0;
  int          fails = 0;
  vec_t        vecs[$];

  vram_arbiter #(.RD_LATENCY(1), .ADDR_W(14)) dut (
    .clk(clk), .reset(reset),
    .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .cpu_addr_wr(cpu_addr_wr), .cpu_data_wr(cpu_data_wr), .cpu_data_rd(cpu_data_rd),
    .cpu_wdata(cpu_wdata), .inc32(inc32), .vblank(vblank),
    .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
    .VRAM_addr(VRAM_addr), .VRAM_WE(VRAM_WE), .VRAM_data_in(VRAM_data_in),
    .VRAM_data_out(VRAM_data_out),
    .palette_WE(palette_WE), .pal_addr(pal_addr), .palette_data_in(palette_data_in)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Synchronous VRAM with one cycle of read latency, read-before-write.
  always @(posedge clk) begin
    VRAM_data_out <= mem[VRAM_addr[13:0]];
    if (VRAM_WE) mem[VRAM_addr[13:0]] <= VRAM_data_in;
  end

  function automatic ins_t mkIn(input logic rr, input logic [15:0] ra, input logic aw,
                                input logic dw, input logic dr, input logic [7:0] wd,
                                input logic i32);
    ins_t s;
    s.rndReq = rr; s.rndAddr = ra; s.addrWr = aw; s.dataWr = dw; s.dataRd = dr;
    s.wdata = wd; s.inc32 = i32; s.vblank = 1'b1;
    return s;
  endfunction

  function automatic outs_t mkOut(input logic rv, input logic [7:0] rd, input logic [15:0] va,
                                  input logic we, input logic [7:0] din, input logic pwe,
                                  input logic [4:0] pa, input logic [7:0] pd,
                                  input logic busy, input logic [7:0] rdata);
    outs_t o;
    o.rndValid = rv; o.rndData = rd; o.vramAddr = va; o.vramWe = we; o.vramDin = din;
    o.palWe = pwe; o.palAddr = pa; o.palDin = pd; o.cpuBusy = busy; o.cpuRdata = rdata;
    return o;
  endfunction

  function automatic outs_t idleOut(input logic [7:0] rdata);
    return mkOut(0, 8'h00, 16'h0000, 0, 8'h00, 0, 5'h00, 8'h00, 0, rdata);
  endfunction

  task automatic addVec(input ins_t s, input outs_t e);
    vec_t v;
    v.stim = s;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic driveInputs(input ins_t s);
    rnd_req = s.rndReq; rnd_addr = s.rndAddr; cpu_addr_wr = s.addrWr;
    cpu_data_wr = s.dataWr; cpu_data_rd = s.dataRd; cpu_wdata = s.wdata;
    inc32 = s.inc32; vblank = s.vblank;
  endtask

  // Data fields are compared only where the matching strobe/valid is expected.
  task automatic checkOutput(input string name, input outs_t e, input bit strict);
    outs_t g;
    outs_t gm;
    g = mkOut(rnd_valid, rnd_data, VRAM_addr, VRAM_WE, VRAM_data_in, palette_WE,
              pal_addr, palette_data_in, cpu_busy, cpu_rdata);
    gm = g;
    if (!strict) begin
      if (!e.rndValid) gm.rndData = e.rndData;
      if (e.palWe) gm.vramAddr = e.vramAddr;
      if (!e.vramWe) gm.vramDin = e.vramDin;
      if (!e.palWe) begin
        gm.palAddr = e.palAddr;
        gm.palDin  = e.palDin;
      end
    end
    vectors++;
    if (gm !== e) begin
      fails++;
      $display("[TB] FAIL %s: got rv=%b rd=%h addr=%h we=%b din=%h pwe=%b pa=%h pd=%h busy=%b rdata=%h; expected rv=%b rd=%h addr=%h we=%b din=%h pwe=%b pa=%h pd=%h busy=%b rdata=%h",
               name, g.rndValid, g.rndData, g.vramAddr, g.vramWe, g.vramDin, g.palWe,
               g.palAddr, g.palDin, g.cpuBusy, g.cpuRdata,
               e.rndValid, e.rndData, e.vramAddr, e.vramWe, e.vramDin, e.palWe,
               e.palAddr, e.palDin, e.cpuBusy, e.cpuRdata);
    end
  endtask

  task automatic applyStimulus(input ins_t s, input outs_t e, input string name);
    @(negedge clk);
    driveInputs(s);
    #2;
    checkOutput(name, e, 1'b0);
  endtask

  // Main sequence: reset, vector table, then multi-cycle corner cases.
  initial begin
    ins_t        s;
    outs_t       e;
    logic [15:0] a;

    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h2400] = 8'h11;
    mem[14'h2401] = 8'h22;
    mem[14'h2F30] = 8'h5C;

    // Stimulus table: one record per cycle.
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), idleOut(8'h00));
    addVec(mkIn(0, 16'h0000, 1, 0, 0, 8'h21, 0), idleOut(8'h00));
    addVec(mkIn(0, 16'h0000, 1, 0, 0, 8'h08, 0), idleOut(8'h00));
    addVec(mkIn(0, 16'h0000, 0, 1, 0, 8'h5A, 0), idleOut(8'h00));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), mkOut(0, 0, 16'h2108, 1, 8'h5A, 0, 0, 0, 1, 8'h00));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), idleOut(8'h00));
    addVec(mkIn(0, 16'h0000, 0, 1, 0, 8'h33, 0), idleOut(8'h00));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), mkOut(0, 0, 16'h2109, 1, 8'h33, 0, 0, 0, 1, 8'h00));
    addVec(mkIn(0, 16'h0000, 1, 0, 0, 8'h24, 0), idleOut(8'h00));
    addVec(mkIn(0, 16'h0000, 1, 0, 0, 8'h00, 0), idleOut(8'h00));
    addVec(mkIn(0, 16'h0000, 0, 0, 1, 8'h00, 0), idleOut(8'h00));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), mkOut(0, 0, 16'h2400, 0, 0, 0, 0, 0, 1, 8'h00));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), idleOut(8'h00));
    addVec(mkIn(0, 16'h0000, 0, 0, 1, 8'h00, 0), idleOut(8'h11));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), mkOut(0, 0, 16'h2401, 0, 0, 0, 0, 0, 1, 8'h11));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), idleOut(8'h11));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), idleOut(8'h22));
    addVec(mkIn(1, 16'hE108, 0, 0, 0, 8'h00, 0), mkOut(0, 0, 16'h2108, 0, 0, 0, 0, 0, 0, 8'h22));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), mkOut(1, 8'h5A, 16'h0000, 0, 0, 0, 0, 0, 0, 8'h22));
    addVec(mkIn(0, 16'h0000, 1, 0, 0, 8'h3F, 0), idleOut(8'h22));
    addVec(mkIn(0, 16'h0000, 1, 0, 0, 8'h10, 0), idleOut(8'h22));
    addVec(mkIn(0, 16'h0000, 0, 1, 0, 8'h0F, 1), idleOut(8'h22));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), mkOut(0, 0, 16'h0000, 0, 0, 1, 5'h00, 8'h0F, 1, 8'h22));
    addVec(mkIn(0, 16'h0000, 0, 0, 1, 8'h00, 0), idleOut(8'h22));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), mkOut(0, 0, 16'h2F30, 0, 0, 0, 0, 0, 1, 8'h22));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), idleOut(8'h22));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), idleOut(8'h5C));
    addVec(mkIn(0, 16'h0000, 1, 0, 0, 8'h3F, 0), idleOut(8'h5C));
    addVec(mkIn(0, 16'h0000, 1, 0, 0, 8'hE0, 0), idleOut(8'h5C));
    addVec(mkIn(0, 16'h0000, 0, 1, 0, 8'h44, 1), idleOut(8'h5C));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), mkOut(0, 0, 16'h0000, 0, 0, 1, 5'h00, 8'h44, 1, 8'h5C));
    addVec(mkIn(0, 16'h0000, 0, 1, 0, 8'h66, 0), idleOut(8'h5C));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), mkOut(0, 0, 16'h0000, 1, 8'h66, 0, 0, 0, 1, 8'h5C));
    addVec(mkIn(0, 16'h0000, 1, 0, 0, 8'h3F, 0), idleOut(8'h5C));
    addVec(mkIn(0, 16'h0000, 1, 0, 0, 8'h1C, 0), idleOut(8'h5C));
    addVec(mkIn(0, 16'h0000, 0, 1, 0, 8'h77, 0), idleOut(8'h5C));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), mkOut(0, 0, 16'h0000, 0, 0, 1, 5'h0C, 8'h77, 1, 8'h5C));
    addVec(mkIn(0, 16'h0000, 0, 1, 0, 8'h88, 0), idleOut(8'h5C));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), mkOut(0, 0, 16'h0000, 0, 0, 1, 5'h1D, 8'h88, 1, 8'h5C));
    addVec(mkIn(0, 16'h0000, 1, 0, 0, 8'h10, 0), idleOut(8'h5C));
    addVec(mkIn(0, 16'h0000, 1, 0, 0, 8'h00, 0), idleOut(8'h5C));
    addVec(mkIn(0, 16'h0000, 0, 1, 0, 8'hAA, 0), idleOut(8'h5C));
    addVec(mkIn(1, 16'h0000, 0, 1, 0, 8'hBB, 0), mkOut(0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 8'h5C));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), mkOut(1, 8'h66, 16'h1000, 1, 8'hAA, 0, 0, 0, 1, 8'h5C));
    addVec(mkIn(0, 16'h0000, 0, 1, 0, 8'hCC, 0), idleOut(8'h5C));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), mkOut(0, 0, 16'h1001, 1, 8'hCC, 0, 0, 0, 1, 8'h5C));
    addVec(mkIn(0, 16'h0000, 0, 1, 1, 8'hDD, 0), idleOut(8'h5C));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), mkOut(0, 0, 16'h1002, 1, 8'hDD, 0, 0, 0, 1, 8'h5C));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), idleOut(8'h5C));
    addVec(mkIn(0, 16'h0000, 1, 1, 0, 8'h21, 0), idleOut(8'h5C));
    addVec(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), mkOut(0, 0, 16'h1003, 1, 8'h21, 0, 0, 0, 1, 8'h5C));
    addVec(mkIn(0, 16'h0000, 1, 0, 0, 8'h00, 0), idleOut(8'h5C));

    // Reset held: every output must be exactly 0 whatever the inputs do.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rnd_req = 1'($urandom); rnd_addr = 16'($urandom);
      cpu_addr_wr = 1'($urandom); cpu_data_wr = 1'($urandom); cpu_data_rd = 1'($urandom);
      cpu_wdata = 8'($urandom); inc32 = 1'($urandom); vblank = 1'($urandom);
      #2;
      checkOutput("reset_hold", '0, 1'b1);
    end
    @(negedge clk);
    driveInputs(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0));
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stim, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Contention: CPU write waits behind 10 renderer cycles, issues on the first free one.
    applyStimulus(mkIn(0, 16'h0000, 1, 0, 0, 8'h30, 0), idleOut(8'h5C), "cont_latch_hi");
    applyStimulus(mkIn(0, 16'h0000, 1, 0, 0, 8'h00, 0), idleOut(8'h5C), "cont_latch_lo");
    for (int i = 0; i < 10; i++) begin
      a = (i % 2 == 0) ? 16'h2400 : 16'h2401;
      s = mkIn(1, a, 0, (i == 0), 0, 8'hE7, 0);
      if (i == 0) e = mkOut(0, 0, a, 0, 0, 0, 0, 0, 0, 8'h5C);
      else        e = mkOut(1, (i % 2 == 1) ? 8'h11 : 8'h22, a, 0, 0, 0, 0, 0, 1, 8'h5C);
      applyStimulus(s, e, $sformatf("cont_rnd%0d", i));
    end
    applyStimulus(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0),
                  mkOut(1, 8'h22, 16'h3000, 1, 8'hE7, 0, 0, 0, 1, 8'h5C), "cont_issue");
    applyStimulus(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), idleOut(8'h5C), "cont_done");

    // vblank gating of CPU issue.
    s = mkIn(0, 16'h0000, 0, 1, 0, 8'h3C, 0);
    s.vblank = 1'b0;
    applyStimulus(s, idleOut(8'h5C), "vbl_capture");
    s = mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0);
    s.vblank = 1'b0;
`ifdef ARB_VBLANK_ONLY_EN
    applyStimulus(s, mkOut(0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 8'h5C), "vbl_hold0");
    applyStimulus(s, mkOut(0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 8'h5C), "vbl_hold1");
    s.vblank = 1'b1;
    applyStimulus(s, mkOut(0, 0, 16'h3001, 1, 8'h3C, 0, 0, 0, 1, 8'h5C), "vbl_issue");
`else
    applyStimulus(s, mkOut(0, 0, 16'h3001, 1, 8'h3C, 0, 0, 0, 1, 8'h5C), "vbl_issue");
`endif
    applyStimulus(mkIn(0, 16'h0000, 0, 0, 0, 8'h00, 0), idleOut(8'h5C), "vbl_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
